key_filter: RTL and testbench
=============================

KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 Parameter CNT_MAX, default 20'd999_999, is the debounce terminal count (20 ms at 50 MHz); the bench overrides it to 9.
REQ-002 Port sys_clk, input, 1, is the single system clock; all state updates on its rising edge.
REQ-003 Port sys_rst_n, input, 1, is the reset: asynchronous assert, active-low.
REQ-004 Port key_in, input, 2, carries the raw asynchronous key levels, active-low (1 = released).
REQ-005 Port key_out, output, 2, carries the debounced key state, active-high (1 = pressed), and feeds the downstream 2-bit in port.
REQ-006 Port key_flag, output, 2, carries the one-cycle press pulse per key and exists only when KEY_FILTER_FLAG_EN is defined.

Function
REQ-007 Each key channel i (0..1) shall be independent, with no shared counter or state.
REQ-008 Each channel shall pass key_in[i] through a 2-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-009 Each channel shall run a 4-state FSM: RELEASED, PRESS_FILT, PRESSED, RELEASE_FILT.
REQ-010 In RELEASED with sync==0, the FSM shall enter PRESS_FILT and clear the counter; otherwise it stays in RELEASED.
REQ-011 In PRESS_FILT with sync==0 and counter<CNT_MAX, the counter shall increment by 1.
REQ-012 In PRESS_FILT with sync==1 (bounce), the FSM shall return to RELEASED and clear the counter.
REQ-013 In PRESS_FILT with sync==0 and counter==CNT_MAX, the FSM shall enter PRESSED, clear the counter and set key_out[i]=1 on the same edge.
REQ-014 PRESSED and RELEASE_FILT shall mirror REQ-010 to REQ-013 with the levels inverted; the exit from RELEASE_FILT to RELEASED clears key_out[i].
REQ-015 Latency: a clean level change on key_in[i] shall reach key_out[i] on the (CNT_MAX+4)th rising edge after the change (2 sync + 1 FSM entry + CNT_MAX+1 count edges).
REQ-016 A bounce shorter than CNT_MAX+1 synchronized cycles shall produce no change on key_out[i].
REQ-017 The counter shall be $clog2(CNT_MAX+1) bits wide, unsigned, shall never exceed CNT_MAX and shall never wrap.
REQ-018 Simultaneous transitions on both keys shall be filtered independently with identical timing.
REQ-019 key_out shall be registered, with no combinational path from key_in.

Reset
REQ-020 While sys_rst_n==0: synchronizer flops = 1, FSM = RELEASED, counters = 0, key_out = 2'b00, key_flag = 2'b00.
REQ-021 Reset asserted mid-filter or mid-press shall abort immediately to the REQ-020 values; after release, a held key re-qualifies with the full REQ-015 latency.

Configuration
REQ-022 With macro KEY_FILTER_FLAG_EN defined, key_flag[i] shall pulse high for exactly one cycle, on the edge where key_out[i] rises (press only, not release).
REQ-023 Without KEY_FILTER_FLAG_EN, port key_flag and its logic shall be absent; all other behaviour is unchanged.

Structure
REQ-024 Package key_filter_pkg shall hold the 2-bit state encoding (RELEASED=0, PRESS_FILT=1, PRESSED=2, RELEASE_FILT=3) and the default CNT_MAX constant.
REQ-025 Per-key logic (synchronizer, FSM, counter, flag) shall live in sub-module key_debounce_ch, instantiated twice by key_filter.

Verification (CNT_MAX=9, 20 ns clock)
REQ-026 Reset: hold sys_rst_n=0 with key_in=2'b00 -> key_out=2'b00 and key_flag=2'b00 throughout.
REQ-027 Clean press: after reset, drive key_in[0]=0 and hold -> key_out[0] rises on the 13th edge, key_flag[0] is high for that single cycle, and key_out[1] stays 0.
REQ-028 Bounce: drive key_in[1] low 5 cycles, high 1, low 5, high -> key_out[1] never rises and key_flag[1] never pulses.
REQ-029 Release: from pressed, drive key_in[0]=1 and hold -> key_out[0] falls on the 13th edge and key_flag[0] does not pulse.
REQ-030 Simultaneous press plus mid-operation reset: drive key_in=2'b00 -> both key_out bits rise on the same edge; assert reset for 1 cycle at count 5 of a later release -> outputs = 0, then both bits re-assert 13 edges after reset release.

Source files
------------

// File: rtl/key_filter_pkg.sv
// Shared encodings and defaults for the two-key debouncer.
package key_filter_pkg;

  localparam int          NUM_KEYS    = 2;
  localparam logic [19:0] CNT_MAX_DEF = 20'd999_999;  // 20 ms at 50 MHz

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_FILT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_FILT = 2'd3
  } key_state_e;

endpackage

// File: rtl/key_filter_if.sv
// Key bus: raw active-low levels in, debounced active-high state (and press pulse
// when KEY_FILTER_FLAG_EN is defined) out.
interface key_filter_if;
  import key_filter_pkg::*;

  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_out;
`ifdef KEY_FILTER_FLAG_EN
  logic [NUM_KEYS-1:0] key_flag;

  modport master (output key_in, input  key_out, input  key_flag);
  modport slave  (input  key_in, output key_out, output key_flag);
`else
  modport master (output key_in, input  key_out);
  modport slave  (input  key_in, output key_out);
`endif
endinterface

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, 4-state filter FSM with saturating counter,
// registered level output and (with KEY_FILTER_FLAG_EN) a one-cycle press pulse.
module key_debounce_ch
  import key_filter_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
`ifdef KEY_FILTER_FLAG_EN
  output logic flag_o,
`endif
  output logic key_o
);

  localparam int             CW   = (CNT_MAX == 20'd0) ? 1 : $clog2(int'(CNT_MAX) + 1);
  localparam logic [CW-1:0]  CMAX = CW'(CNT_MAX);

  logic [1:0]    sync_q;
  logic          sync;
  key_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_q, out_d;
  logic          rise;

  assign sync = sync_q[1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      state_q <= RELEASED;
      cnt_q   <= '0;
      out_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  // Filter states count while the level stays at its new value; any reversion
  // drops straight back with the counter cleared.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise    = 1'b0;
    case (state_q)
      RELEASED: if (!sync) begin
        state_d = PRESS_FILT;
        cnt_d   = '0;
      end
      PRESS_FILT: begin
        if (sync) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CMAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          out_d   = 1'b1;
          rise    = 1'b1;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PRESSED: if (sync) begin
        state_d = RELEASE_FILT;
        cnt_d   = '0;
      end
      RELEASE_FILT: begin
        if (!sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CMAX) begin
          state_d = RELEASED;
          cnt_d   = '0;
          out_d   = 1'b0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_o = out_q;

`ifdef KEY_FILTER_FLAG_EN
  logic flag_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) flag_q <= 1'b0;
    else         flag_q <= rise;
  end

  assign flag_o = flag_q;
`else
  logic unused_rise;
  assign unused_rise = rise;
`endif

endmodule

// File: rtl/key_filter.sv
// Two independent key debouncers behind the key_filter_if bus.
// Optional press pulse output enabled by defining KEY_FILTER_FLAG_EN.
module key_filter
  import key_filter_pkg::*;
#(
  parameter logic [19:0] CNT_MAX = CNT_MAX_DEF
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  key_filter_if.slave kif
);

  logic [NUM_KEYS-1:0] key_out_w;
`ifdef KEY_FILTER_FLAG_EN
  logic [NUM_KEYS-1:0] key_flag_w;
  assign kif.key_flag = key_flag_w;
`endif

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    key_debounce_ch #(.CNT_MAX(CNT_MAX)) u_ch (
      .clk_i  (sys_clk),
      .rst_ni (sys_rst_n),
      .key_i  (kif.key_in[g]),
`ifdef KEY_FILTER_FLAG_EN
      .flag_o (key_flag_w[g]),
`endif
      .key_o  (key_out_w[g])
    );
  end

  assign kif.key_out = key_out_w;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter with CNT_MAX=9: directed vector table, hand-written reset
// sequence and randomized key activity checked against a run-length reference model.
module tb_key_filter;

  localparam int CM = 9;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  key_filter_if kif();

  key_filter #(.CNT_MAX(20'd9)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .kif       (kif)
  );

  always #10 sys_clk = ~sys_clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: raw samples age through a 2-deep delay, then a key flips once
  // its delayed level has disagreed with the reported state for CM+2 straight edges.
  logic [1:0] m_d1, m_d2, m_out;
  int         m_run [2];
`ifdef KEY_FILTER_FLAG_EN
  logic [1:0] m_flag;
`endif

  typedef struct {
    logic [1:0] key;
    int         hold;
    logic [1:0] eout;
    logic [1:0] eflag;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_d1 = 2'b11;
    m_d2 = 2'b11;
    m_out = 2'b00;
    m_run[0] = 0;
    m_run[1] = 0;
`ifdef KEY_FILTER_FLAG_EN
    m_flag = 2'b00;
`endif
  endtask

  task automatic step();
    logic [1:0] seen;
    @(posedge sys_clk);
    if (!sys_rst_n) model_reset();
    else begin
      seen = m_d2;
      m_d2 = m_d1;
      m_d1 = kif.key_in;
`ifdef KEY_FILTER_FLAG_EN
      m_flag = 2'b00;
`endif
      for (int k = 0; k < 2; k++) begin
        // A raw 0 means pressed; it disagrees with the state when it equals out.
        if (seen[k] == m_out[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == CM + 2) begin
          m_out[k] = ~m_out[k];
          m_run[k] = 0;
`ifdef KEY_FILTER_FLAG_EN
          m_flag[k] = m_out[k];
`endif
        end
      end
    end
    #1;
    check("model_key_out", kif.key_out, m_out);
`ifdef KEY_FILTER_FLAG_EN
    check("model_key_flag", kif.key_flag, m_flag);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    sys_rst_n  = 1'b0;
    kif.key_in = 2'b00;
    #1;
    check("reset_async_out", kif.key_out, 2'b00);
    for (int i = 0; i < 5; i++) step();
    check("reset_hold_out", kif.key_out, 2'b00);
`ifdef KEY_FILTER_FLAG_EN
    check("reset_hold_flag", kif.key_flag, 2'b00);
`endif
    kif.key_in = 2'b11;
    step();
    sys_rst_n = 1'b1;

    // key, hold edges, expected key_out / key_flag after the last edge
    tbl.push_back('{2'b11,  4, 2'b00, 2'b00});
    tbl.push_back('{2'b10, 12, 2'b00, 2'b00});  // press key0: nothing yet at edge 12
    tbl.push_back('{2'b10,  1, 2'b01, 2'b01});  // edge 13 rises, pulse
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00});  // pulse lasted one cycle
    tbl.push_back('{2'b00,  5, 2'b01, 2'b00});  // key1 bounce: low 5
    tbl.push_back('{2'b10,  1, 2'b01, 2'b00});  //   high 1
    tbl.push_back('{2'b00,  5, 2'b01, 2'b00});  //   low 5
    tbl.push_back('{2'b10, 20, 2'b01, 2'b00});  //   high, never pressed
    tbl.push_back('{2'b11, 12, 2'b01, 2'b00});  // release key0
    tbl.push_back('{2'b11,  1, 2'b00, 2'b00});  // falls on edge 13, no pulse
    tbl.push_back('{2'b00, 12, 2'b00, 2'b00});  // simultaneous press
    tbl.push_back('{2'b00,  1, 2'b11, 2'b11});
    tbl.push_back('{2'b00,  3, 2'b11, 2'b00});

    foreach (tbl[v]) begin
      kif.key_in = tbl[v].key;
      for (int i = 0; i < tbl[v].hold; i++) step();
      check($sformatf("vec%0d_out", v), kif.key_out, tbl[v].eout);
`ifdef KEY_FILTER_FLAG_EN
      check($sformatf("vec%0d_flag", v), kif.key_flag, tbl[v].eflag);
`endif
    end

    // Release both, reset at count 5 of the release filter, keys held pressed after.
    kif.key_in = 2'b11;
    for (int i = 0; i < 8; i++) step();
    check("pre_reset_out", kif.key_out, 2'b11);
    #4;
    sys_rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_reset_out", kif.key_out, 2'b00);
    kif.key_in = 2'b00;
    step();
    sys_rst_n = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step();
      check($sformatf("requal_edge%0d", i), kif.key_out, (i == 13) ? 2'b11 : 2'b00);
    end

    // Random activity: each key toggles with ~1/10 probability per cycle so hold
    // times straddle the qualification length.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 9) == 0) kif.key_in[k] = ~kif.key_in[k];
      if (i % 50 == 0 && $urandom_range(0, 3) == 0) kif.key_in = ~kif.key_in;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
